// File: rtl/enc_pkg.sv
// Shared sizes and types for the pending priority encoder.
// N request lines, W-bit encoded index.
package enc_pkg;

    localparam int N = 8;
    localparam int W = $clog2(N);

    typedef logic [W-1:0] idx_t;
    typedef logic [N-1:0] vec_t;

endpackage

// File: rtl/decoder_3_8.sv
// Enabled 3-to-8 one-hot decoder.
// Out is all zeros while E is low.
module decoder_3_8
    import enc_pkg::*;
(
    input  logic E,
    input  idx_t In,
    output vec_t Out
);

    // One-hot expansion of In, gated by E
    always_comb begin
        Out = '0;
        if (E) begin
            Out[In] = 1'b1;
        end
    end

endmodule

// File: rtl/prio_enc_8_3.sv
// Combinational 8-to-3 priority encoder.
// Highest set bit wins; any flags a non-empty input.
module prio_enc_8_3
    import enc_pkg::*;
(
    input  vec_t vec,
    output logic any,
    output idx_t idx
);

    // Scan upward so the highest set bit is the last to write idx
    always_comb begin
        any = |vec;
        idx = '0;
        for (int i = 0; i < N; i++) begin
            if (vec[i]) begin
                idx = idx_t'(i);
            end
        end
    end

endmodule

// File: rtl/pending_encoder_8_3.sv
// Sequential 8-to-3 priority encoder with a pending set.
// Issues the highest pending index over valid/ready.
module pending_encoder_8_3
    import enc_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic E,
    input  vec_t In,
    output idx_t Out,
    output logic valid,
    input  logic ready,
    output vec_t pending,
    output logic ovf,
    input  logic clr_ovf
);

    vec_t pending_q, pending_d;
    idx_t out_q, out_d;
    logic valid_q, valid_d;
    logic ovf_q, ovf_d;

    logic any;
    idx_t sel;
    logic free;
    logic load;
    vec_t clr_mask;
    vec_t req;

    prio_enc_8_3 u_prio (
        .vec (pending_q),
        .any (any),
        .idx (sel)
    );

    decoder_3_8 u_dec (
        .E   (load),
        .In  (sel),
        .Out (clr_mask)
    );

    // Output stage is free when empty or being drained this edge
    always_comb begin
        free = !valid_q || ready;
        load = free && any;
        req  = E ? In : '0;
    end

    // Next state: set wins over the issue clear and over clr_ovf
    always_comb begin
        out_d     = out_q;
        valid_d   = valid_q;
        pending_d = (pending_q & ~clr_mask) | req;
        ovf_d     = (ovf_q && !clr_ovf) ||
                    (|(req & pending_q & ~clr_mask));
        if (free) begin
            valid_d = any;
            if (load) begin
                out_d = sel;
            end
        end
    end

    // State registers, cleared immediately by rst
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_q <= '0;
            out_q     <= '0;
            valid_q   <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            pending_q <= pending_d;
            out_q     <= out_d;
            valid_q   <= valid_d;
            ovf_q     <= ovf_d;
        end
    end

    assign Out     = out_q;
    assign valid   = valid_q;
    assign pending = pending_q;
    assign ovf     = ovf_q;

endmodule

// File: tb/tb_pending_encoder_8_3.sv
// Directed self-checking bench for pending_encoder_8_3.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_pending_encoder_8_3;

    logic       clk = 1'b0;
    logic       rst;
    logic       E;
    logic [7:0] In;
    logic [2:0] Out;
    logic       valid;
    logic       ready;
    logic [7:0] pending;
    logic       ovf;
    logic       clr_ovf;

    int errors = 0;
    int checks = 0;

    pending_encoder_8_3 dut (
        .clk     (clk),
        .rst     (rst),
        .E       (E),
        .In      (In),
        .Out     (Out),
        .valid   (valid),
        .ready   (ready),
        .pending (pending),
        .ovf     (ovf),
        .clr_ovf (clr_ovf)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Checks Out, valid, pending and ovf together
    task automatic chk_all(input string tag, input logic [2:0] o,
                           input logic v, input logic [7:0] p,
                           input logic f);
        chk({tag, ".valid"}, 32'(valid), 32'(v));
        if (v) chk({tag, ".Out"}, 32'(Out), 32'(o));
        chk({tag, ".pending"}, 32'(pending), 32'(p));
        chk({tag, ".ovf"}, 32'(ovf), 32'(f));
    endtask

    initial begin
        rst = 1'b1; E = 1'b0; In = 8'h00;
        ready = 1'b0; clr_ovf = 1'b0;
        #2;
        chk_all("reset0", 3'd0, 1'b0, 8'h00, 1'b0);
        chk("reset0.Out", 32'(Out), 32'd0);
        step();
        rst = 1'b0;

        // Reset mid-transfer: fill everything, then async reset
        E = 1'b1; In = 8'hFF;
        step();
        chk_all("fill1", 3'd0, 1'b0, 8'hFF, 1'b0);
        step();
        chk_all("fill2", 3'd7, 1'b1, 8'hFF, 1'b1);
        In = 8'h00;
        #2;
        rst = 1'b1;
        #1;
        chk_all("async_rst", 3'd0, 1'b0, 8'h00, 1'b0);
        chk("async_rst.Out", 32'(Out), 32'd0);
        step();
        rst = 1'b0;

        // Single request, two edges to valid
        ready = 1'b1; In = 8'h20;
        step();
        chk_all("single.k", 3'd0, 1'b0, 8'h20, 1'b0);
        In = 8'h00;
        step();
        chk_all("single.k1", 3'd5, 1'b1, 8'h00, 1'b0);
        step();
        chk_all("single.k2", 3'd0, 1'b0, 8'h00, 1'b0);

        // Priority drain of 8'hA5
        In = 8'hA5;
        step();
        chk_all("drain.load", 3'd0, 1'b0, 8'hA5, 1'b0);
        In = 8'h00;
        step();
        chk_all("drain.7", 3'd7, 1'b1, 8'h25, 1'b0);
        step();
        chk_all("drain.5", 3'd5, 1'b1, 8'h05, 1'b0);
        step();
        chk_all("drain.2", 3'd2, 1'b1, 8'h01, 1'b0);
        step();
        chk_all("drain.0", 3'd0, 1'b1, 8'h00, 1'b0);
        step();
        chk_all("drain.end", 3'd0, 1'b0, 8'h00, 1'b0);

        // Backpressure with 8'h0C
        ready = 1'b0; In = 8'h0C;
        step();
        chk_all("bp.load", 3'd0, 1'b0, 8'h0C, 1'b0);
        In = 8'h00;
        step();
        chk_all("bp.issue", 3'd3, 1'b1, 8'h04, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step();
            chk_all("bp.hold", 3'd3, 1'b1, 8'h04, 1'b0);
        end
        ready = 1'b1;
        step();
        chk_all("bp.2", 3'd2, 1'b1, 8'h00, 1'b0);
        step();
        chk_all("bp.end", 3'd0, 1'b0, 8'h00, 1'b0);

        // Coalesce: stall the stage with index 1, then 8'h10 twice
        ready = 1'b0; In = 8'h02;
        step();
        In = 8'h00;
        step();
        chk_all("co.stall", 3'd1, 1'b1, 8'h00, 1'b0);
        In = 8'h10;
        step();
        chk_all("co.first", 3'd1, 1'b1, 8'h10, 1'b0);
        In = 8'h00;
        step();
        In = 8'h10;
        step();
        chk_all("co.second", 3'd1, 1'b1, 8'h10, 1'b1);
        clr_ovf = 1'b1;
        step();
        chk_all("co.set_wins", 3'd1, 1'b1, 8'h10, 1'b1);
        In = 8'h00;
        step();
        chk_all("co.clr", 3'd1, 1'b1, 8'h10, 1'b0);
        clr_ovf = 1'b0; ready = 1'b1;
        step();
        chk_all("co.drain4", 3'd4, 1'b1, 8'h00, 1'b0);
        step();
        chk_all("co.end", 3'd0, 1'b0, 8'h00, 1'b0);

        // Set wins over clear in the issue cycle
        In = 8'h10;
        step();
        chk_all("sw.load", 3'd0, 1'b0, 8'h10, 1'b0);
        step();
        chk_all("sw.issue1", 3'd4, 1'b1, 8'h10, 1'b0);
        In = 8'h00;
        step();
        chk_all("sw.issue2", 3'd4, 1'b1, 8'h00, 1'b0);
        step();
        chk_all("sw.end", 3'd4, 1'b0, 8'h00, 1'b0);
        chk("sw.Out_hold", 32'(Out), 32'd4);

        // E=0 masks requests
        E = 1'b0; In = 8'hFF;
        step();
        chk_all("e0.1", 3'd0, 1'b0, 8'h00, 1'b0);
        step();
        chk_all("e0.2", 3'd0, 1'b0, 8'h00, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
